// File: rtl/accel_regs_pkg.sv
// accel_regs_pkg: ADXL345-style register addresses, reset values and responder FSM states
package accel_regs_pkg;
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
  localparam logic [7:0] BW_RATE_RST      = 8'h0A;
  localparam logic [7:0] POWER_CTL_RST    = 8'h00;
  localparam logic [7:0] INT_ENABLE_RST   = 8'h00;
  localparam logic [7:0] DATA_FORMAT_RST  = 8'h00;
  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_e;
  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer with single-cycle rise/fall pulses
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: oversampled SPI mode-3 slave emulating the ADXL345 register interface
module accel_spi_responder
  import accel_regs_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic        int1,
  output logic        measure_en,
  output logic        busy
);
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] sdi_q, sdi_d;
  state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d;
  logic [5:0] addr_q, addr_d;
  logic mb_q, mb_d, sdo_q, sdo_d;
  logic [7:0] bw_q, bw_d, pwr_q, pwr_d, ien_q, ien_d, fmt_q, fmt_d;
  logic [5:0][7:0] data_q, data_d;
  logic [47:0] pend_q, pend_d;
  logic pend_v_q, pend_v_d, hit_q, hit_d, dr_q, dr_d, int1_q, int1_d;
  logic [7:0] rx_byte;
  logic [5:0] next_addr;
  logic byte_done, idle, apply, clear;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );
  // csn starts "selected" so a master still holding CS_N low across reset cannot fake a cs_fall
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_csn_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_csn), .rise(cs_rise), .fall(cs_fall)
  );

  function automatic logic [7:0] reg_rd(input logic [5:0] a);
    case (a)
      ADDR_DEVID:       return DEVID;
      ADDR_BW_RATE:     return bw_q;
      ADDR_POWER_CTL:   return pwr_q;
      ADDR_INT_ENABLE:  return ien_q;
      ADDR_INT_SOURCE:  return {dr_q, 7'h02};
      ADDR_DATA_FORMAT: return fmt_q;
      ADDR_DATAX0:      return data_q[0];
      ADDR_DATAX1:      return data_q[1];
      ADDR_DATAY0:      return data_q[2];
      ADDR_DATAY1:      return data_q[3];
      ADDR_DATAZ0:      return data_q[4];
      ADDR_DATAZ1:      return data_q[5];
      default:          return 8'h00;
    endcase
  endfunction

  always_comb begin
    sdi_d = {sdi_q[SYNC_STAGES-2:0], spi_sdi};
    state_d = state_q;
    bit_d = bit_q;
    rx_d = rx_q;
    tx_d = tx_q;
    addr_d = addr_q;
    mb_d = mb_q;
    sdo_d = sdo_q;
    bw_d = bw_q;
    pwr_d = pwr_q;
    ien_d = ien_q;
    fmt_d = fmt_q;
    data_d = data_q;
    pend_d = pend_q;
    pend_v_d = pend_v_q;
    hit_d = hit_q;
    rx_byte = {rx_q[6:0], sdi_q[SYNC_STAGES-1]};
    next_addr = mb_q ? addr_q + 6'd1 : addr_q;
    byte_done = sclk_rise && (bit_q == 3'd7);
    case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall) begin
          state_d = CMD;
          bit_d = 3'd0;
        end
      end
      CMD: if (sclk_rise) begin
        rx_d = rx_byte;
        bit_d = bit_q + 3'd1;
        if (byte_done) begin
          mb_d = rx_byte[6];
          addr_d = rx_byte[5:0];
          tx_d = reg_rd(rx_byte[5:0]);
          state_d = rx_byte[7] ? RD : WR;
        end
      end
      RD: begin
        if (sclk_fall) begin
          sdo_d = tx_q[7];
          tx_d = {tx_q[6:0], 1'b0};
        end
        if (sclk_rise) bit_d = bit_q + 3'd1;
        if (byte_done) begin
          addr_d = next_addr;
          tx_d = reg_rd(next_addr);
          hit_d = hit_q | is_data_addr(addr_q);
        end
      end
      WR: begin
        if (sclk_rise) begin
          rx_d = rx_byte;
          bit_d = bit_q + 3'd1;
        end
        if (byte_done) begin
          addr_d = next_addr;
          bw_d = (addr_q == ADDR_BW_RATE) ? rx_byte : bw_q;
          pwr_d = (addr_q == ADDR_POWER_CTL) ? rx_byte : pwr_q;
          ien_d = (addr_q == ADDR_INT_ENABLE) ? rx_byte : ien_q;
          fmt_d = (addr_q == ADDR_DATA_FORMAT) ? rx_byte : fmt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
    // data regs only move while idle; the read-clear is deferred to the same idle cycle so a new sample wins
    idle = state_q == IDLE;
    apply = idle && (sample_valid || pend_v_q);
    clear = idle && hit_q;
    if (!idle && sample_valid) begin
      pend_v_d = 1'b1;
      pend_d = {sample_z, sample_y, sample_x};
    end
    if (apply) begin
      data_d = sample_valid ? {sample_z, sample_y, sample_x} : pend_q;
      pend_v_d = 1'b0;
    end
    if (clear) hit_d = 1'b0;
    dr_d = (apply && pwr_q[3]) ? 1'b1 : clear ? 1'b0 : dr_q;
    int1_d = dr_q & ien_q[7];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdi_q <= '0;
      state_q <= IDLE;
      bit_q <= 3'd0;
      rx_q <= 8'h00;
      tx_q <= 8'h00;
      addr_q <= 6'd0;
      mb_q <= 1'b0;
      sdo_q <= 1'b0;
      bw_q <= BW_RATE_RST;
      pwr_q <= POWER_CTL_RST;
      ien_q <= INT_ENABLE_RST;
      fmt_q <= DATA_FORMAT_RST;
      data_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      hit_q <= 1'b0;
      dr_q <= 1'b0;
      int1_q <= 1'b0;
    end else begin
      sdi_q <= sdi_d;
      state_q <= state_d;
      bit_q <= bit_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      addr_q <= addr_d;
      mb_q <= mb_d;
      sdo_q <= sdo_d;
      bw_q <= bw_d;
      pwr_q <= pwr_d;
      ien_q <= ien_d;
      fmt_q <= fmt_d;
      data_q <= data_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      hit_q <= hit_d;
      dr_q <= dr_d;
      int1_q <= int1_d;
    end
  end

  assign spi_sdo = sdo_q;
  assign spi_sdo_oe = state_q == RD;
  assign busy = state_q != IDLE;
  assign int1 = int1_q;
  assign measure_en = pwr_q[3];
endmodule
